// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared constants and types for the Aurora 64b/66b receive path.
//   AURORA_BLOCK_W : width of one 64b/66b block (2-bit sync header + 64 payload)
//   SERDES_WORD_W  : width of the word delivered by the SERDES each cycle
//   GBOX_BUF_W     : gearbox sliding-buffer width (128-bit aligner offset
//                    range plus one block)
//   gbox_state_t   : gearbox FSM state (priming the buffer, or running)
// ---------------------------------------------------------------------------
package rx_pkg;

  localparam int AURORA_BLOCK_W = 66;
  localparam int SERDES_WORD_W  = 32;
  localparam int GBOX_BUF_W     = 194;

  typedef enum logic {GB_FILL, GB_RUN} gbox_state_t;

endpackage

// File: rtl/rx_gearbox.sv
// ---------------------------------------------------------------------------
// rx_gearbox
// RX gearbox for the Aurora 64b/66b path. SERDES words are shifted into a
// sliding buffer. Once enough bits have arrived to fill the buffer, a
// one-cycle pulse is produced each time another 66 new bits have arrived,
// and the residual bit count is reported so the aligner can find the block.
//
// Ports
//   clk_i       in   recovered-word clock
//   rst_ni      in   asynchronous reset, active-low
//   data_i      in   SERDES word
//   data_vld_i  in   data_i valid this cycle
//   flush_i     in   synchronous flush/resync request (flush beats data)
//   gbox_buffer out  sliding buffer, newest bits at [WORD_W-1:0]
//   gbox_cnt    out  bits newer than the completed block (0..31)
//   buffer_dv   out  one-cycle pulse, a full new block is in gbox_buffer
//   primed_o    out  buffer has been completely filled since reset/flush
//
// The completed block sits at gbox_buffer[gbox_cnt+BLOCK_W-1 : gbox_cnt].
// ---------------------------------------------------------------------------
module rx_gearbox
  import rx_pkg::*;
#(
  parameter int WORD_W  = SERDES_WORD_W,
  parameter int BLOCK_W = AURORA_BLOCK_W,
  parameter int BUF_W   = GBOX_BUF_W,
  parameter bit BIT_REV = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WORD_W-1:0] data_i,
  input  logic              data_vld_i,
  input  logic              flush_i,
  output logic [BUF_W-1:0]  gbox_buffer,
  output logic [5:0]        gbox_cnt,
  output logic              buffer_dv,
  output logic              primed_o
);

  // 7 bits covers the largest fill + WORD_W value (64 + 32 = 96).
  localparam logic [6:0] WORD_INC   = 7'(WORD_W);
  localparam logic [6:0] BLOCK_LEN  = 7'(BLOCK_W);
  // Seven words (224 bits) are the first count that covers the whole buffer.
  localparam logic [2:0] PRIME_LAST = 3'd6;

  logic [WORD_W-1:0] word;
  gbox_state_t       state;
  logic [6:0]        fill;
  logic [6:0]        nf;
  logic [2:0]        prime_cnt;

  // Optional SERDES bit-order swap, resolved at elaboration time.
  for (genvar i = 0; i < WORD_W; i++) begin : g_bitrev
    if (BIT_REV) begin : g_rev
      assign word[i] = data_i[WORD_W-1-i];
    end else begin : g_fwd
      assign word[i] = data_i[i];
    end
  end

  assign nf = fill + WORD_INC;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gbox_buffer <= '0;
      gbox_cnt    <= '0;
      buffer_dv   <= 1'b0;
      primed_o    <= 1'b0;
      state       <= GB_FILL;
      fill        <= '0;
      prime_cnt   <= '0;
    end else if (flush_i) begin
      // The buffer contents are kept; they will be displaced during FILL.
      gbox_cnt    <= '0;
      buffer_dv   <= 1'b0;
      primed_o    <= 1'b0;
      state       <= GB_FILL;
      fill        <= '0;
      prime_cnt   <= '0;
    end else if (data_vld_i) begin
      gbox_buffer <= {gbox_buffer[BUF_W-WORD_W-1:0], word};
      if (state == GB_FILL) begin
        buffer_dv <= 1'b0;
        prime_cnt <= prime_cnt + 3'd1;
        if (prime_cnt == PRIME_LAST) begin
          state    <= GB_RUN;
          primed_o <= 1'b1;
        end
      end else begin
        // nf < 2*BLOCK_W, so at most one block completes per word and
        // buffer_dv can never be high two cycles running.
        if (nf >= BLOCK_LEN) begin
          buffer_dv <= 1'b1;
          fill      <= nf - BLOCK_LEN;
          gbox_cnt  <= 6'(nf - BLOCK_LEN);
        end else begin
          buffer_dv <= 1'b0;
          fill      <= nf;
        end
      end
    end else begin
      buffer_dv <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_gearbox.sv
// ---------------------------------------------------------------------------
// tb_rx_gearbox
// Directed bench for rx_gearbox. Each step drives one cycle of inputs and
// checks the registered outputs one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_rx_gearbox;

  logic         clk_i;
  logic         rst_ni;
  logic [31:0]  data_i;
  logic         data_vld_i;
  logic         flush_i;
  logic [193:0] gbox_buffer;
  logic [5:0]   gbox_cnt;
  logic         buffer_dv;
  logic         primed_o;

  int vectors;
  int miscompares;

  // Bench copy of the buffer shift: reset clears it, flush leaves it alone.
  logic [193:0] modelBuf;

  rx_gearbox dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .data_vld_i  (data_vld_i),
    .flush_i     (flush_i),
    .gbox_buffer (gbox_buffer),
    .gbox_cnt    (gbox_cnt),
    .buffer_dv   (buffer_dv),
    .primed_o    (primed_o)
  );

  // Free-running 10-unit clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // One comparison: count it, and count plus report it if it misses.
  task automatic checkOutput(input string tag, input logic [193:0] obs,
                             input logic [193:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, and return 1 unit later.
  task automatic applyStimulus(input logic [31:0] d, input logic vld,
                               input logic fl);
    data_i     = d;
    data_vld_i = vld;
    flush_i    = fl;
    if (!fl && vld) modelBuf = {modelBuf[161:0], d};
    @(posedge clk_i);
    #1;
    data_vld_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  // Synchronous-looking reset sequence used between scenarios.
  task automatic doReset();
    rst_ni   = 1'b0;
    modelBuf = '0;
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Seven words fill the buffer; afterwards the run starts with fill = 0.
  task automatic doPrime(input string tag);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus({16'h5EED, 16'(i)}, 1'b1, 1'b0);
      checkOutput({tag, "_dv"}, 194'(buffer_dv), 194'(1'b0));
    end
    checkOutput({tag, "_primed"}, 194'(primed_o), 194'(1'b1));
  endtask

  initial begin
    logic         expDv;
    logic [5:0]   expCnt;
    logic [193:0] shifted;
    logic [65:0]  blockExp;
    int           pulses;

    vectors     = 0;
    miscompares = 0;
    modelBuf    = '0;
    rst_ni      = 1'b0;
    data_i      = '0;
    data_vld_i  = 1'b0;
    flush_i     = 1'b0;

    // Reset state.
    #12;
    checkOutput("rst_buf",    gbox_buffer,         194'(0));
    checkOutput("rst_cnt",    194'(gbox_cnt),      194'(0));
    checkOutput("rst_dv",     194'(buffer_dv),     194'(0));
    checkOutput("rst_primed", 194'(primed_o),      194'(0));
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Scenario 1: seven all-ones words prime the buffer.
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b0);
      checkOutput("s1_dv",     194'(buffer_dv), 194'(0));
      checkOutput("s1_primed", 194'(primed_o),  194'(i == 7));
    end
    checkOutput("s1_buf", gbox_buffer, {194{1'b1}});

    // Scenario 2: 33 back-to-back words give 16 pulses, cnt 30 down to 0.
    pulses = 0;
    for (int i = 1; i <= 33; i++) begin
      applyStimulus({16'hC0DE, 16'(i)}, 1'b1, 1'b0);
      expDv  = (i >= 3) && (i % 2 == 1);
      expCnt = (i < 3) ? 6'd0 : ((i % 2 == 1) ? 6'(33 - i) : 6'(34 - i));
      checkOutput($sformatf("s2_dv_w%0d", i),  194'(buffer_dv), 194'(expDv));
      checkOutput($sformatf("s2_cnt_w%0d", i), 194'(gbox_cnt),  194'(expCnt));
      if (buffer_dv) pulses++;
    end
    checkOutput("s2_pulses", 194'(pulses), 194'(16));

    // Scenario 3: a single marker bit travels into a known block position.
    applyStimulus(32'h0000_0001, 1'b1, 1'b0);
    checkOutput("s3_dv1", 194'(buffer_dv), 194'(0));
    applyStimulus(32'h0000_0000, 1'b1, 1'b0);
    checkOutput("s3_dv2", 194'(buffer_dv), 194'(0));
    applyStimulus(32'h0000_0000, 1'b1, 1'b0);
    checkOutput("s3_dv3",    194'(buffer_dv), 194'(1));
    checkOutput("s3_cnt",    194'(gbox_cnt),  194'(30));
    checkOutput("s3_buf",    gbox_buffer,     modelBuf);
    checkOutput("s3_marker", 194'(gbox_buffer[64]), 194'(1));
    // Block spans [95:30]; the marker at buffer bit 64 is block bit 34.
    blockExp = 66'd1 << 34;
    shifted  = gbox_buffer >> gbox_cnt;
    checkOutput("s3_block", 194'(shifted[65:0]), 194'(blockExp));

    // Scenario 4: valid toggled every cycle gives the same sequence.
    doReset();
    doPrime("s4_prime");
    pulses = 0;
    for (int i = 1; i <= 33; i++) begin
      applyStimulus({16'hB00C, 16'(i)}, 1'b1, 1'b0);
      expDv  = (i >= 3) && (i % 2 == 1);
      expCnt = (i < 3) ? 6'd0 : ((i % 2 == 1) ? 6'(33 - i) : 6'(34 - i));
      checkOutput($sformatf("s4_dv_w%0d", i),  194'(buffer_dv), 194'(expDv));
      checkOutput($sformatf("s4_cnt_w%0d", i), 194'(gbox_cnt),  194'(expCnt));
      if (buffer_dv) pulses++;
      applyStimulus(32'hDEAD_BEEF, 1'b0, 1'b0);
      checkOutput($sformatf("s4_idle_dv%0d", i),  194'(buffer_dv), 194'(0));
      checkOutput($sformatf("s4_idle_cnt%0d", i), 194'(gbox_cnt),  194'(expCnt));
    end
    checkOutput("s4_pulses", 194'(pulses), 194'(16));
    checkOutput("s4_buf",    gbox_buffer,  modelBuf);

    // Scenario 5: flush with a valid word mid-run, then re-prime.
    for (int i = 1; i <= 4; i++) applyStimulus({16'hF1F1, 16'(i)}, 1'b1, 1'b0);
    checkOutput("s5_pre_cnt", 194'(gbox_cnt), 194'(30));
    applyStimulus(32'h1234_5678, 1'b1, 1'b1);
    checkOutput("s5_dv",     194'(buffer_dv), 194'(0));
    checkOutput("s5_primed", 194'(primed_o),  194'(0));
    checkOutput("s5_cnt",    194'(gbox_cnt),  194'(0));
    checkOutput("s5_buf",    gbox_buffer,     modelBuf);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus({16'hAAAA, 16'(i)}, 1'b1, 1'b0);
      checkOutput("s5_fill_dv",     194'(buffer_dv), 194'(0));
      checkOutput("s5_fill_primed", 194'(primed_o),  194'(i == 7));
    end
    for (int i = 1; i <= 3; i++) begin
      applyStimulus({16'hBBBB, 16'(i)}, 1'b1, 1'b0);
      checkOutput($sformatf("s5_run_dv%0d", i), 194'(buffer_dv), 194'(i == 3));
    end
    checkOutput("s5_run_cnt", 194'(gbox_cnt), 194'(30));
    checkOutput("s5_run_buf", gbox_buffer,    modelBuf);

    // Scenario 6: asynchronous reset between clock edges mid-run.
    applyStimulus(32'h7777_7777, 1'b1, 1'b0);
    checkOutput("s6_pre_primed", 194'(primed_o), 194'(1));
    #3;
    rst_ni   = 1'b0;
    modelBuf = '0;
    #1;
    checkOutput("s6_buf",    gbox_buffer,     194'(0));
    checkOutput("s6_cnt",    194'(gbox_cnt),  194'(0));
    checkOutput("s6_dv",     194'(buffer_dv), 194'(0));
    checkOutput("s6_primed", 194'(primed_o),  194'(0));
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    doPrime("s6_prime");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus({16'hCCCC, 16'(i)}, 1'b1, 1'b0);
      checkOutput($sformatf("s6_run_dv%0d", i), 194'(buffer_dv), 194'(i == 3));
    end
    checkOutput("s6_run_cnt", 194'(gbox_cnt), 194'(30));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
